// File: rtl/spm_conflict_scheduler_if.sv
// Request/issue bundle between the SPM input stage, the conflict scheduler and the bank array.
// The slave modport is the scheduler's view; master is the surrounding logic's view.
interface spm_conflict_scheduler_if #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = $clog2(LANES + 1)
);
  logic                    req_valid;
  logic                    req_ready;
  logic [LANES-1:0]        req_mask;
  logic [LANES*ADDR_W-1:0] req_addr;
  logic                    issue_valid;
  logic                    issue_ready;
  logic [LANES-1:0]        issue_mask;
  logic                    issue_last;
  logic [CNT_W-1:0]        issue_iter;
  logic [LANES-1:0]        pending_mask;
  logic                    done;

  modport master (
    output req_valid, req_mask, req_addr, issue_ready,
    input  req_ready, issue_valid, issue_mask, issue_last, issue_iter, pending_mask, done
  );

  modport slave (
    input  req_valid, req_mask, req_addr, issue_ready,
    output req_ready, issue_valid, issue_mask, issue_last, issue_iter, pending_mask, done
  );
endinterface

// File: rtl/spm_conflict_scheduler.sv
// Splits one vector request into bank-conflict-free iterations; first issue one cycle after accept.
// Issue outputs hold while issue_ready is low; no new request is taken until the pending set drains.
module spm_conflict_scheduler #(
  parameter int LANES  = 16,
  parameter int BANKS  = 16,
  parameter int ADDR_W = 32,
  parameter int BANK_W = $clog2(BANKS),
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  spm_conflict_scheduler_if.slave    bus
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q [LANES];
  logic [LANES-1:0]  pending_q;
  logic [LANES-1:0]  pending_d;
  logic [CNT_W-1:0]  iter_q;
  logic              done_q;

  logic [LANES-1:0]  sat_mask;
  logic [ADDR_W-1:0] win_addr;
  logic              win_found;

  // Each lane looks up the lowest pending lane of its own bank; matching addresses broadcast.
  always_comb begin
    sat_mask  = '0;
    win_addr  = '0;
    win_found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      win_addr  = '0;
      win_found = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (!win_found && pending_q[j] &&
            (addr_q[j][BANK_W-1:0] == addr_q[i][BANK_W-1:0])) begin
          win_found = 1'b1;
          win_addr  = addr_q[j];
        end
      end
      sat_mask[i] = pending_q[i] && win_found && (win_addr == addr_q[i]);
    end
  end

  assign pending_d = pending_q & ~sat_mask;

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.issue_valid  = (state_q == ISSUE);
  assign bus.issue_mask   = (state_q == ISSUE) ? sat_mask : '0;
  assign bus.issue_last   = (state_q == ISSUE) && (pending_d == '0);
  assign bus.issue_iter   = iter_q;
  assign bus.pending_mask = pending_q;
  assign bus.done         = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            for (int i = 0; i < LANES; i++) begin
              addr_q[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
            end
            pending_q <= bus.req_mask;
            iter_q    <= '0;
            if (bus.req_mask != '0) begin
              state_q <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.issue_ready) begin
            pending_q <= pending_d;
            iter_q    <= iter_q + 1'b1;
            if (pending_d == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spm_conflict_scheduler.md
# spm_conflict_scheduler

Sequencing controller for the scratchpad memory bank array. It accepts one vector request (up to `LANES` lane addresses plus a lane mask) and resolves bank conflicts by issuing the lanes to the banks over successive iterations. Each iteration issues the lanes that can be served together, then clears them from the pending set, and it repeats until no lane is pending. It sits between the SPM input stage and the bank array, and supplies the per-iteration satisfied lane mask that drives bank enables and output data collection.

## Interface
Parameters:
- `LANES`, 16: number of lanes in a vector request.
- `BANKS`, 16: number of SPM banks; power of two.
- `ADDR_W`, 32: word address width per lane.
- `BANK_W`, $clog2(BANKS): bank index width; the bank index is `addr[BANK_W-1:0]`.
- `CNT_W`, $clog2(LANES+1): iteration counter width.

Ports (clock and reset are fixed: one clock, synchronous active-high reset):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  scheduler idle and able to accept a request.
- `req_mask`  in  LANES  active lanes of the request.
- `req_addr`  in  LANES*ADDR_W  lane i address at `[i*ADDR_W +: ADDR_W]`.
- `issue_valid`  out  1  an iteration is presented to the banks.
- `issue_ready`  in  1  banks accept the iteration this cycle.
- `issue_mask`  out  LANES  lanes satisfied by this iteration.
- `issue_last`  out  1  this iteration empties the pending set.
- `issue_iter`  out  CNT_W  index of this iteration, starting at 0.
- `pending_mask`  out  LANES  lanes still unserved.
- `done`  out  1  one-cycle pulse when the request completes.

## Operation
- FSM states are IDLE and ISSUE. Reset enters IDLE.
- In IDLE, `req_ready`=1. On `req_valid && req_ready`, the block registers the addresses, loads the pending register with `req_mask`, and clears the iteration counter.
  - If `req_mask`≠0, the next state is ISSUE.
  - If `req_mask`=0, the state stays IDLE and `done` pulses in the following cycle. No issue is made.
- Winner of bank b: the lowest-index pending lane whose bank index equals b.
- Lane i is satisfied when all three hold:
  - lane i is pending;
  - its bank has a winner w;
  - `addr[i]==addr[w]` (full ADDR_W compare).
- Consequences of the satisfied rule:
  - Equal addresses in the same bank are broadcast, i.e. served in the same iteration.
  - Different addresses in the same bank are conflicts and wait for a later iteration.
- In ISSUE:
  - `issue_valid`=1.
  - `issue_mask` = satisfied set, computed combinationally from the registered pending mask and addresses.
  - `issue_last` = (pending & ~issue_mask)==0.
- When `issue_valid && issue_ready`:
  - pending ← pending & ~issue_mask;
  - iteration counter += 1;
  - if `issue_last`, the next state is IDLE and `done` pulses in the next cycle.
- When `issue_ready`=0, all outputs and state hold, and `issue_mask` stays stable.
- `issue_mask` is never zero in ISSUE, because the lowest pending lane always wins its own bank. Progress of at least one lane per iteration is therefore guaranteed.
- Number of iterations = max over banks of the count of distinct addresses in that bank, within 1..LANES.
- `req_ready`=0 in ISSUE. A request can never be accepted while pending≠0.

## Timing
- Reset values: state IDLE, pending 0, counter 0, `req_ready`=1, `issue_valid`=0, `issue_mask`=0, `issue_last`=0, `issue_iter`=0, `pending_mask`=0, `done`=0.
- Reset mid-ISSUE: the next cycle is IDLE with all reset values. The in-flight request is discarded and no `done` is produced.
- Accept at cycle T. The first `issue_valid` occurs at T+1.
- With `issue_ready` held at 1 and N iterations:
  - issues occur in cycles T+1..T+N;
  - `issue_last` is asserted at T+N;
  - `done` pulses at T+N+1, together with `req_ready`=1;
  - the next request can be accepted at T+N+1.
- Empty request: `done` pulses at T+1 with no issue cycles.
- `done` is registered. The issue outputs are combinational from registered state only; there is no combinational path from `issue_ready` to any of them.

## Test plan
- 16 lanes, all lanes in distinct banks (addr = i): one iteration with `issue_mask`=0xFFFF and `issue_last`=1, `done` at T+2.
- All 16 lanes at addr 0x40 (same bank, same address): one broadcast iteration, mask 0xFFFF.
- All lanes in bank 0 with distinct addresses (addr = i*16): 16 iterations with masks 0x0001, 0x0002, … 0x8000, and `issue_iter` running 0..15.
- Mixed case:
  - Stimulus: lanes 0, 2 at 0x10; lane 1 at 0x20 (both bank 0); lane 3 at 0x03.
  - Required: masks 0x000D then 0x0002, with `issue_last` on the second iteration.
- Backpressure: drop `issue_ready` for 3 cycles in the middle of the bank-0 case. The mask, `issue_iter` and `pending_mask` hold, and the total is 16 accepted issues.
- Assert `reset` during the 5th iteration: IDLE next cycle, `req_ready`=1, and no `done`. A subsequent `req_mask`=0 request gives `done` at T+1.
